// File: rtl/spi_flash_read_ctrl.sv
// spi_flash_read_ctrl: SPI mode-0 master issuing single-word 03h READ frames to a serial NOR flash.
// Define FLASH_CTRL_BSWAP_EN to return the word byte-swapped (byte at the address in bits [7:0]).
module spi_flash_read_ctrl #(
  parameter int unsigned DIV = 2,
  parameter logic [7:0] CMD_READ = 8'h03
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, DESEL, RESP} state_t;
  state_t state, state_n;
  logic [7:0] div_cnt;
  logic [5:0] bit_cnt;
  logic [63:0] sh;
  logic [31:0] cap, word, resp_q;
  logic tick, timed;
  assign timed = state inside {SETUP, SHIFT_HI, SHIFT_LO, DESEL};
  assign tick = timed && div_cnt == 8'(DIV - 1);
`ifdef FLASH_CTRL_BSWAP_EN
  assign word = {cap[7:0], cap[15:8], cap[23:16], cap[31:24]};
`else
  assign word = cap;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      cap <= '0;
      resp_q <= '0;
    end else begin
      state <= state_n;
      div_cnt <= (!timed || tick) ? 8'd0 : div_cnt + 8'd1;
      if (state == IDLE && req_valid) begin
        sh <= {CMD_READ, req_addr, 32'h0};
        bit_cnt <= '0;
      end else if (tick && state == SHIFT_HI && bit_cnt != 6'd63)
        sh <= {sh[62:0], 1'b0};
      if (tick && state == SHIFT_LO) bit_cnt <= bit_cnt + 6'd1;
      // data bits 32..63 are sampled on the edge that raises sck for that bit
      if (tick && state == SHIFT_LO && bit_cnt >= 6'd31) cap <= {cap[30:0], miso};
      if (tick && state == DESEL) resp_q <= word;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (req_valid) state_n = SETUP;
      SETUP:    if (tick) state_n = SHIFT_HI;
      SHIFT_HI: if (tick) state_n = bit_cnt == 6'd63 ? DESEL : SHIFT_LO;
      SHIFT_LO: if (tick) state_n = SHIFT_HI;
      DESEL:    if (tick) state_n = RESP;
      RESP:     if (resp_ready) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    resp_data = resp_q;
    busy = timed;
    sck = state == SHIFT_HI;
    ss = !(state inside {SETUP, SHIFT_HI, SHIFT_LO});
    mosi = sh[63];
  end
endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// tb_spi_flash_read_ctrl: random reads through DIV=2 and DIV=1 controllers against a mode-0 flash model.
module tb_spi_flash_read_ctrl;
  logic clock = 1'b0, reset, req_valid, resp_ready, miso = 1'b0, sel;
  logic [23:0] req_addr;
  logic rr2, rv2, bz2, sck2, ss2, mo2, rr1, rv1, bz1, sck1, ss1, mo1;
  logic [31:0] rd2, rd1;
  logic req_ready, resp_valid, busy, sck, ss, mosi;
  logic [31:0] resp_data;
  logic [7:0] seed;
  int div, cyc = 0, total = 0, bad = 0;
  int nbits = 0, frame_edges = 0, gap = 0, last_gap = 0;
  logic [63:0] rx = '0, frame_rx = '0;
  logic [31:0] fdata = '0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  spi_flash_read_ctrl #(.DIV(2)) dut2 (.clock(clock), .reset(reset), .req_valid(req_valid && !sel),
    .req_ready(rr2), .req_addr(req_addr), .resp_valid(rv2), .resp_ready(resp_ready && !sel),
    .resp_data(rd2), .busy(bz2), .sck(sck2), .ss(ss2), .mosi(mo2), .miso(miso));
  spi_flash_read_ctrl #(.DIV(1)) dut1 (.clock(clock), .reset(reset), .req_valid(req_valid && sel),
    .req_ready(rr1), .req_addr(req_addr), .resp_valid(rv1), .resp_ready(resp_ready && sel),
    .resp_data(rd1), .busy(bz1), .sck(sck1), .ss(ss1), .mosi(mo1), .miso(miso));
  assign div = sel ? 1 : 2;
  assign req_ready = sel ? rr1 : rr2;
  assign resp_valid = sel ? rv1 : rv2;
  assign resp_data = sel ? rd1 : rd2;
  assign busy = sel ? bz1 : bz2;
  assign sck = sel ? sck1 : sck2;
  assign ss = sel ? ss1 : ss2;
  assign mosi = sel ? mo1 : mo2;
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return (a >= 24'h10 && a <= 24'h13) ? (a[7:0] - 8'h0f) * 8'h11 : a[7:0] ^ a[15:8] ^ a[23:16] ^ seed;
  endfunction
  function automatic logic [31:0] raw_word(input logic [23:0] a);
    return {mem_byte(a), mem_byte(a + 24'd1), mem_byte(a + 24'd2), mem_byte(a + 24'd3)};
  endfunction
  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [31:0] w;
    w = raw_word(a);
`ifdef FLASH_CTRL_BSWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction
  // mode-0 flash: shifts mosi in on sck rise, presents data on sck fall
  always @(posedge sck) if (!ss) begin
    rx = {rx[62:0], mosi};
    nbits++;
    if (nbits == 32) fdata = raw_word(rx[23:0]);
  end
  always @(negedge sck) if (!ss && nbits >= 32 && nbits < 64) miso = fdata[63 - nbits];
  always @(posedge ss) begin
    frame_rx = rx;
    frame_edges = nbits;
    nbits = 0;
  end
  always @(negedge clock) if (ss) gap++; else if (gap > 0) begin
    last_gap = gap;
    gap = 0;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_read(input logic [23:0] a, input int bp, input bit keep);
    int n, t0;
    logic [31:0] e;
    e = exp_word(a);
    req_addr = a;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clock); n++; end
    chk("accept_timeout", 64'(n < 2000), 64'd1);
    t0 = cyc + 1;
    @(negedge clock);
    if (!keep) req_valid = 1'b0;
    chk("busy_frame", 64'(busy), 64'd1);
    chk("ss_low", 64'(ss), 64'd0);
    n = 0;
    while (!resp_valid && n < 2000) begin @(negedge clock); n++; end
    chk("latency", 64'(cyc - t0), 64'(129 * div));
    chk("cmd", 64'(frame_rx[63:56]), 64'h03);
    chk("addr", 64'(frame_rx[55:32]), 64'(a));
    chk("edges", 64'(frame_edges), 64'd64);
    chk("data", 64'(resp_data), 64'(e));
    chk("busy_resp", 64'(busy), 64'd0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clock);
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_data", 64'(resp_data), 64'(e));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_ss", 64'(ss), 64'd1);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    chk("ready_after_hs", 64'(req_ready), 64'd1);
    chk("valid_drop", 64'(resp_valid), 64'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bit seen;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0; sel = 1'b0;
    seed = 8'($urandom);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_ss", 64'(ss), 64'd1);
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_mosi", 64'(mosi), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    do_read(24'h000010, 0, 1'b0);
    do_read(24'h000010, 10, 1'b0);
    do_read(24'h000010, 0, 1'b1);
    do_read(24'hFFFFFC, 0, 1'b0);
    chk("desel_gap", 64'(last_gap >= div), 64'd1);
    req_addr = 24'h000010;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (nbits < 41 && n < 2000) begin @(negedge clock); n++; end
    chk("abort_reach", 64'(nbits), 64'd41);
    #2 reset = 1'b1;
    #1;
    chk("abort_ss", 64'(ss), 64'd1);
    chk("abort_sck", 64'(sck), 64'd0);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clock);
      if (resp_valid) seen = 1'b1;
    end
    chk("abort_no_resp", 64'(seen), 64'd0);
    do_read(24'h000010, 0, 1'b0);
    sel = 1'b1;
    do_read(24'h000010, 0, 1'b0);
    do_read(24'hFFFFFC, 3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom_range(0, 1));
      do_read(24'($urandom), $urandom_range(0, 4), i < 7 ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    req_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
